// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus bundle: ICache-side packet input, decode-side single
// instruction output, flush and fence.i sideband, and the occupancy count.
//   master : fetch/decode environment (drives in_*, out_ready, isFlush, fencei_valid)
//   slave  : the queue itself
interface inst_fetch_queue_if #(
   parameter int DEPTH = 8,
   parameter int ENQ_W = 2,
   parameter int XLEN  = 32
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                  in_valid;
   logic                  in_ready;
   logic [ENQ_W*XLEN-1:0] in_bits_inst;
   logic [XLEN-1:0]       in_bits_pc;
   logic [ENQ_W-1:0]      in_bits_mask;
   logic                  out_valid;
   logic                  out_ready;
   logic [XLEN-1:0]       out_bits_inst;
   logic [XLEN-1:0]       out_bits_pc;
   logic                  isFlush;
   logic                  fencei_valid;
   logic                  fencei_done;
   logic [CW-1:0]         count;

   modport master (
      output in_valid, in_bits_inst, in_bits_pc, in_bits_mask,
      output out_ready, isFlush, fencei_valid,
      input  in_ready, out_valid, out_bits_inst, out_bits_pc, fencei_done, count
   );

   modport slave (
      input  in_valid, in_bits_inst, in_bits_pc, in_bits_mask,
      input  out_ready, isFlush, fencei_valid,
      output in_ready, out_valid, out_bits_inst, out_bits_pc, fencei_done, count
   );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: circular buffer between the ICache response path
// and the decode port. Accepts packets of up to ENQ_W instructions (per-slot
// mask, compacted in slot order), delivers one instruction+PC per cycle.
// Supports redirect flush and a fence.i drain handshake.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   fq    : inst_fetch_queue_if.slave (packet in, instruction out, flush,
//           fence.i request/done, occupancy count)
//
// state | meaning
// IDLE  | normal operation, packets accepted when room
// DRAIN | fence.i pending: no new packets, dequeue continues until empty
// DONE  | queue drained: fencei_done pulses for this one cycle
module inst_fetch_queue #(
   parameter int DEPTH = 8,
   parameter int ENQ_W = 2,
   parameter int XLEN  = 32
) (
   input logic               clock,
   input logic               reset,
   inst_fetch_queue_if.slave fq
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_DONE} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic [XLEN-1:0] inst_mem_q [DEPTH];
   logic [XLEN-1:0] pc_mem_q [DEPTH];

   logic [DEPTH-1:0] wr_en;
   logic [XLEN-1:0]  wr_inst [DEPTH];
   logic [XLEN-1:0]  wr_pc [DEPTH];
   logic [CW-1:0]    enq_cnt;
   logic [AW-1:0]    wr_idx;
   logic             in_ready, out_valid, enq_fire, deq_fire;

   // Reset gating keeps in_ready low while reset is held even though the
   // registered state already reads as idle/empty.
   assign in_ready  = reset && ((CW'(DEPTH) - count_q) >= CW'(ENQ_W))
                      && !fq.isFlush && (state_q == ST_IDLE);
   assign out_valid = (count_q != '0) && !fq.isFlush;
   assign enq_fire  = fq.in_valid && in_ready;
   assign deq_fire  = out_valid && fq.out_ready;

   assign fq.in_ready      = in_ready;
   assign fq.out_valid     = out_valid;
   assign fq.out_bits_inst = inst_mem_q[head_q];
   assign fq.out_bits_pc   = pc_mem_q[head_q];
   assign fq.fencei_done   = (state_q == ST_DONE);
   assign fq.count         = count_q;

   // Compact the set mask bits into consecutive entries starting at tail.
   always_comb begin
      wr_en   = '0;
      enq_cnt = '0;
      wr_idx  = '0;
      for (int e = 0; e < DEPTH; e++) begin
         wr_inst[e] = '0;
         wr_pc[e]   = '0;
      end
      for (int i = 0; i < ENQ_W; i++) begin
         if (fq.in_bits_mask[i]) begin
            wr_idx          = tail_q + AW'(enq_cnt);
            wr_en[wr_idx]   = 1'b1;
            wr_inst[wr_idx] = fq.in_bits_inst[i*XLEN +: XLEN];
            wr_pc[wr_idx]   = fq.in_bits_pc + XLEN'(4 * i);
            enq_cnt         = enq_cnt + CW'(1);
         end
      end
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (fq.isFlush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enq_fire) tail_d = tail_q + AW'(enq_cnt);
         if (deq_fire) head_d = head_q + AW'(1);
         count_d = count_q + (enq_fire ? enq_cnt : CW'(0)) - (deq_fire ? CW'(1) : CW'(0));
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (fq.fencei_valid) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (!fq.fencei_valid)                          state_d = ST_IDLE;
            else if ((count_q == '0) || fq.isFlush)        state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage is cleared on reset so the head read-out is zero while in reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int e = 0; e < DEPTH; e++) begin
            inst_mem_q[e] <= '0;
            pc_mem_q[e]   <= '0;
         end
      end else if (enq_fire && !fq.isFlush) begin
         for (int e = 0; e < DEPTH; e++) begin
            if (wr_en[e]) begin
               inst_mem_q[e] <= wr_inst[e];
               pc_mem_q[e]   <= wr_pc[e];
            end
         end
      end
   end
endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;
   localparam int DEPTH = 8;
   localparam int ENQ_W = 2;
   localparam int XLEN  = 32;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   inst_fetch_queue_if #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .XLEN(XLEN)) fq ();

   inst_fetch_queue #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .XLEN(XLEN)) dut (
      .clock (clock),
      .reset (reset),
      .fq    (fq)
   );

   // Reference model: ordered list of {pc, inst}, plus fence.i phase
   // (0 = accepting, 1 = draining, 2 = done-pulse cycle).
   logic [2*XLEN-1:0] mq[$];
   int mmode;
   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      bit ev, ir, enq, deq;
      int sz;
      sz = mq.size();
      ev = (sz != 0) && !fq.isFlush;
      ir = reset && ((DEPTH - sz) >= ENQ_W) && !fq.isFlush && (mmode == 0);
      chk("out_valid", fq.out_valid, ev);
      chk("in_ready", fq.in_ready, ir);
      chk("count", fq.count, sz);
      chk("fencei_done", fq.fencei_done, mmode == 2);
      if (ev) begin
         chk("out_inst", fq.out_bits_inst, mq[0][XLEN-1:0]);
         chk("out_pc", fq.out_bits_pc, mq[0][2*XLEN-1:XLEN]);
      end
      if (!reset) begin
         mq.delete();
         mmode = 0;
         return;
      end
      enq = fq.in_valid && ir;
      deq = ev && fq.out_ready;
      if (mmode == 0)      mmode = fq.fencei_valid ? 1 : 0;
      else if (mmode == 1) mmode = !fq.fencei_valid ? 0 : ((sz == 0 || fq.isFlush) ? 2 : 1);
      else                 mmode = 0;
      if (fq.isFlush) mq.delete();
      else begin
         if (deq) void'(mq.pop_front());
         if (enq)
            for (int i = 0; i < ENQ_W; i++)
               if (fq.in_bits_mask[i])
                  mq.push_back({fq.in_bits_pc + XLEN'(4 * i), fq.in_bits_inst[i*XLEN +: XLEN]});
      end
   endtask

   task automatic tick();
      #1;
      check_model();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      fq.in_valid     = 1'b0;
      fq.in_bits_mask = '0;
      fq.isFlush      = 1'b0;
      fq.out_ready    = 1'b0;
   endtask

   task automatic push(input logic [ENQ_W-1:0] m);
      fq.in_valid     = 1'b1;
      fq.in_bits_mask = m;
      fq.in_bits_inst = {$urandom, $urandom};
      fq.in_bits_pc   = $urandom & 32'hFFFF_FFFC;
      tick();
      fq.in_valid = 1'b0;
   endtask

   a_count_bound: assert property (@(posedge clock) disable iff (!reset) fq.count <= DEPTH)
      else begin n_fail++; $display("FAIL count_bound: actual=%0d required<=%0d", fq.count, DEPTH); end

   initial begin
      int pulses, pulse_at;
      idle_inputs();
      fq.fencei_valid = 1'b0;
      fq.in_bits_inst = '0;
      fq.in_bits_pc   = '0;
      mmode = 0;

      // Reset state
      #1;
      chk("rst_out_valid", fq.out_valid, 0);
      chk("rst_in_ready", fq.in_ready, 0);
      chk("rst_count", fq.count, 0);
      chk("rst_fencei_done", fq.fencei_done, 0);
      chk("rst_out_inst", fq.out_bits_inst, 0);
      chk("rst_out_pc", fq.out_bits_pc, 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      #1 chk("rel_in_ready", fq.in_ready, 1);
      for (int i = 0; i < 10; i++) tick();

      // Two-slot packet then drain
      fq.in_valid     = 1'b1;
      fq.in_bits_mask = 2'b11;
      fq.in_bits_inst = {32'h0000_0093, 32'h0010_0113};
      fq.in_bits_pc   = 32'h8000_0000;
      fq.out_ready    = 1'b1;
      tick();
      fq.in_valid = 1'b0;
      #1;
      chk("t2_count0", fq.count, 2);
      chk("t2_instA", fq.out_bits_inst, 32'h0010_0113);
      chk("t2_pcA", fq.out_bits_pc, 32'h8000_0000);
      tick();
      #1;
      chk("t2_count1", fq.count, 1);
      chk("t2_instB", fq.out_bits_inst, 32'h0000_0093);
      chk("t2_pcB", fq.out_bits_pc, 32'h8000_0004);
      tick();
      #1 chk("t2_count2", fq.count, 0);

      // Upper-slot-only packet, fill to DEPTH-1
      fq.out_ready    = 1'b0;
      fq.in_valid     = 1'b1;
      fq.in_bits_mask = 2'b10;
      fq.in_bits_inst = {32'hDEAD_0001, 32'h1111_2222};
      fq.in_bits_pc   = 32'h8000_0010;
      tick();
      fq.in_valid = 1'b0;
      #1;
      chk("t3_count", fq.count, 1);
      chk("t3_pc", fq.out_bits_pc, 32'h8000_0014);
      chk("t3_inst", fq.out_bits_inst, 32'hDEAD_0001);
      for (int i = 0; i < 3; i++) push(2'b11);
      #1;
      chk("t3_full_count", fq.count, 7);
      chk("t3_full_in_ready", fq.in_ready, 0);
      fq.out_ready = 1'b1;
      tick();
      fq.out_ready = 1'b0;
      #1;
      chk("t3_after_deq_count", fq.count, 6);
      chk("t3_after_deq_in_ready", fq.in_ready, 1);
      push(2'b11);
      push(2'b01);
      fq.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      fq.out_ready = 1'b0;

      // Flush with same-cycle enqueue
      push(2'b11);
      push(2'b11);
      push(2'b01);
      #1 chk("t4_count5", fq.count, 5);
      fq.isFlush      = 1'b1;
      fq.in_valid     = 1'b1;
      fq.in_bits_mask = 2'b11;
      fq.out_ready    = 1'b1;
      #1;
      chk("t4_flush_out_valid", fq.out_valid, 0);
      chk("t4_flush_in_ready", fq.in_ready, 0);
      tick();
      idle_inputs();
      #1;
      chk("t4_count_after", fq.count, 0);
      chk("t4_out_valid_after", fq.out_valid, 0);

      // fence.i drain from count=3
      push(2'b11);
      push(2'b01);
      fq.fencei_valid = 1'b1;
      fq.out_ready    = 1'b1;
      pulses = 0;
      pulse_at = -1;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (fq.fencei_done) begin
            pulses++;
            if (pulse_at < 0) pulse_at = i;
         end
         tick();
         if (pulse_at >= 0) fq.fencei_valid = 1'b0;
      end
      chk("t5_pulses", pulses, 1);
      chk("t5_pulse_cycle", pulse_at, 4);
      idle_inputs();

      // Async reset mid-stream in DRAIN
      push(2'b11);
      push(2'b11);
      fq.fencei_valid = 1'b1;
      tick();
      #2;
      reset = 1'b0;
      #1;
      chk("t6_count", fq.count, 0);
      chk("t6_out_valid", fq.out_valid, 0);
      chk("t6_in_ready", fq.in_ready, 0);
      chk("t6_fencei_done", fq.fencei_done, 0);
      mq.delete();
      mmode = 0;
      @(posedge clock);
      @(negedge clock);
      fq.fencei_valid = 1'b0;
      reset = 1'b1;
      tick();

      // Randomised traffic
      for (int c = 0; c < 3000; c++) begin
         fq.in_valid     = ($urandom_range(0, 3) != 0);
         fq.in_bits_mask = ENQ_W'($urandom);
         fq.in_bits_inst = {$urandom, $urandom};
         fq.in_bits_pc   = $urandom & 32'hFFFF_FFFC;
         fq.out_ready    = ($urandom_range(0, 9) < 6);
         fq.isFlush      = ($urandom_range(0, 39) == 0);
         if (!fq.fencei_valid)
            fq.fencei_valid = ($urandom_range(0, 59) == 0);
         else if (mmode == 2)
            fq.fencei_valid = 1'b0;
         else if (mmode == 1 && $urandom_range(0, 49) == 0)
            fq.fencei_valid = 1'b0;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
